// File: rtl/tx_arb_pkg.sv
// Shared encodings for the USB transmit packet arbiter: FSM states, packet
// classes, SYNC byte and PID nibbles.
package tx_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SYNC    = 3'd1;
  localparam state_t ST_PID     = 3'd2;
  localparam state_t ST_PAYLOAD = 3'd3;
  localparam state_t ST_CRC_LO  = 3'd4;
  localparam state_t ST_CRC_HI  = 3'd5;
  localparam state_t ST_GAP     = 3'd6;

  typedef enum logic {
    CLS_HS  = 1'b0,
    CLS_DAT = 1'b1
  } pkt_class_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  // On the wire a PID byte carries its check nibble (complement) in the top half.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/tx_gap_timer.sv
// Loadable down-counter timing the idle gap between packets; done is high
// once the loaded count has been walked down to zero. GAP_CYCLES must be >= 1.
module tx_gap_timer #(
  parameter int GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(GAP_CYCLES - 1);

  logic [W-1:0] count;

  // Loaded with GAP_CYCLES-1 so that exactly GAP_CYCLES enabled cycles pass
  // before done is observed high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/tx_packet_arbiter.sv
// Arbitrates the USB transmit byte path between the handshake responder and
// the data path, framing each packet as SYNC, PID, payload, CRC16 with EOP.
module tx_packet_arbiter
  import tx_arb_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int MAX_LEN    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_req,
  input  logic [3:0]  hs_pid,
  output logic        hs_grant,
  input  logic        dat_req,
  input  logic [3:0]  dat_pid,
  input  logic [6:0]  dat_len,
  output logic        dat_grant,
  input  logic        pay_empty,
  input  logic [7:0]  pay_data,
  output logic        pay_pop,
  input  logic [15:0] crc_in,
  input  logic        tx_ready,
  output logic        tx_load,
  output logic [7:0]  tx_byte,
  output logic        tx_eop,
  output logic        tx_abort,
  output logic        busy,
  output logic        underrun
);

  localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

  state_t     state;
  state_t     next_state;
  pkt_class_t cls;
  logic [3:0] pid_q;
  logic [6:0] cnt;
  logic [1:0] hs_streak;
  logic       gap_load;
  logic       gap_done;
  logic       hs_win;
  logic       dat_win;
  logic [6:0] len_clamped;

  // Handshake wins unless it has already taken two grants in a row while data waited.
  assign hs_win      = hs_req && !(dat_req && (hs_streak == 2'd2));
  assign dat_win     = dat_req && !hs_win;
  assign len_clamped = (dat_len > MAX_LEN_W) ? MAX_LEN_W : dat_len;
  assign busy        = (state != ST_IDLE);

  tx_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk (clk),
    .rst (rst),
    .load(gap_load),
    .en  (state == ST_GAP),
    .done(gap_done)
  );

  always_comb begin
    next_state = state;
    tx_load    = 1'b0;
    tx_byte    = 8'h00;
    tx_eop     = 1'b0;
    pay_pop    = 1'b0;
    tx_abort   = 1'b0;
    underrun   = 1'b0;
    gap_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hs_win || dat_win) next_state = ST_SYNC;
      end
      ST_SYNC: begin
        tx_load = tx_ready;
        tx_byte = SYNC_BYTE;
        if (tx_ready) next_state = ST_PID;
      end
      ST_PID: begin
        tx_load = tx_ready;
        tx_byte = pid_byte(pid_q);
        if (tx_ready) begin
          if (cls == CLS_HS) begin
            tx_eop     = 1'b1;
            gap_load   = 1'b1;
            next_state = ST_GAP;
          end else if (cnt == 7'd0) begin
            next_state = ST_CRC_LO;
          end else begin
            next_state = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        // An empty FIFO mid-payload kills the packet; nothing is loaded that cycle.
        if (pay_empty) begin
          tx_abort   = 1'b1;
          underrun   = 1'b1;
          gap_load   = 1'b1;
          next_state = ST_GAP;
        end else begin
          tx_load = tx_ready;
          tx_byte = pay_data;
          pay_pop = tx_ready;
          if (tx_ready && (cnt == 7'd1)) next_state = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        tx_load = tx_ready;
        tx_byte = crc_in[7:0];
        if (tx_ready) next_state = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        tx_load = tx_ready;
        tx_byte = crc_in[15:8];
        tx_eop  = tx_ready;
        if (tx_ready) begin
          gap_load   = 1'b1;
          next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_done) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cls       <= CLS_HS;
      pid_q     <= 4'd0;
      cnt       <= 7'd0;
      hs_streak <= 2'd0;
      hs_grant  <= 1'b0;
      dat_grant <= 1'b0;
    end else begin
      state     <= next_state;
      hs_grant  <= 1'b0;
      dat_grant <= 1'b0;
      if (state == ST_IDLE) begin
        if (hs_win) begin
          hs_grant <= 1'b1;
          cls      <= CLS_HS;
          pid_q    <= hs_pid;
          cnt      <= 7'd0;
          if (dat_req) hs_streak <= hs_streak + 2'd1;
        end else if (dat_win) begin
          dat_grant <= 1'b1;
          cls       <= CLS_DAT;
          pid_q     <= dat_pid;
          cnt       <= len_clamped;
          hs_streak <= 2'd0;
        end
      end else if ((state == ST_PAYLOAD) && tx_load) begin
        cnt <= cnt - 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Scoreboard bench for tx_packet_arbiter: expected bytes and grant classes
// are queued as packets are requested and popped as the DUT loads them.
module tb_tx_packet_arbiter;
  import tx_arb_pkg::*;

  localparam int GAP_CYCLES = 16;
  localparam int MAX_LEN    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_req, dat_req;
  logic [3:0]  hs_pid, dat_pid;
  logic [6:0]  dat_len;
  logic        hs_grant, dat_grant;
  logic        pay_empty;
  logic [7:0]  pay_data;
  logic        pay_pop;
  logic [15:0] crc_in;
  logic        tx_ready;
  logic        tx_load, tx_eop, tx_abort, busy, underrun;
  logic [7:0]  tx_byte;

  tx_packet_arbiter #(
    .GAP_CYCLES(GAP_CYCLES),
    .MAX_LEN   (MAX_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hs_req   (hs_req),
    .hs_pid   (hs_pid),
    .hs_grant (hs_grant),
    .dat_req  (dat_req),
    .dat_pid  (dat_pid),
    .dat_len  (dat_len),
    .dat_grant(dat_grant),
    .pay_empty(pay_empty),
    .pay_data (pay_data),
    .pay_pop  (pay_pop),
    .crc_in   (crc_in),
    .tx_ready (tx_ready),
    .tx_load  (tx_load),
    .tx_byte  (tx_byte),
    .tx_eop   (tx_eop),
    .tx_abort (tx_abort),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]  exp_q[$];
  pkt_class_t  exp_grant[$];
  logic [7:0]  fifo[$];

  int n_checks = 0;
  int n_bad = 0;
  int grant_cnt = 0;
  int pop_cnt = 0;
  int abort_cnt = 0;
  int exp_aborts = 0;
  int last_grant_cyc = 0;
  int abort_cyc = 0;
  int last_busy_cyc = 0;
  bit pop_pend = 1'b0;
  bit rand_ready = 1'b0;
  pkt_class_t mon_g;
  logic [8:0] mon_e;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic refreshFifo();
    pay_empty = (fifo.size() == 0);
    pay_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  // Predicts the byte stream of one packet from the current FIFO contents.
  task automatic pushPacket(input pkt_class_t c, input logic [3:0] pid, input logic [6:0] len);
    int eff;
    int k;
    exp_grant.push_back(c);
    exp_q.push_back({1'b0, SYNC_BYTE});
    if (c == CLS_HS) begin
      exp_q.push_back({1'b1, ~pid, pid});
    end else begin
      exp_q.push_back({1'b0, ~pid, pid});
      eff = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
      k = (fifo.size() < eff) ? fifo.size() : eff;
      for (int i = 0; i < k; i++) exp_q.push_back({1'b0, fifo[i]});
      if (k == eff) begin
        exp_q.push_back({1'b0, crc_in[7:0]});
        exp_q.push_back({1'b1, crc_in[15:8]});
      end else begin
        exp_aborts++;
      end
    end
  endtask

  task automatic waitGrants(input int target, input int budget);
    int n;
    n = 0;
    while ((grant_cnt < target) && (n < budget)) begin
      tick();
      n++;
    end
    checkOutput("grant_count", 32'(grant_cnt), 32'(target));
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || busy) && (n < budget)) begin
      tick();
      n++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    checkOutput("idle", 32'(busy), 32'd0);
  endtask

  task automatic applyStimulus(input pkt_class_t c, input logic [3:0] pid, input logic [6:0] len);
    int target;
    pushPacket(c, pid, len);
    target = grant_cnt + 1;
    if (c == CLS_HS) begin
      hs_pid = pid;
      hs_req = 1'b1;
    end else begin
      dat_pid = pid;
      dat_len = len;
      dat_req = 1'b1;
    end
    waitGrants(target, 200);
    if (c == CLS_HS) hs_req = 1'b0;
    else dat_req = 1'b0;
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) last_busy_cyc = cyc;
      if (hs_grant || dat_grant) begin
        grant_cnt++;
        last_grant_cyc = cyc;
        if (exp_grant.size() == 0) begin
          checkOutput("extra_grant", 32'd1, 32'd0);
        end else begin
          mon_g = exp_grant.pop_front();
          checkOutput("grant_class", 32'({hs_grant, dat_grant}), (mon_g == CLS_HS) ? 32'd2 : 32'd1);
        end
      end
      if (tx_load) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_load", 32'(tx_byte), 32'h100);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("tx_byte", 32'(tx_byte), 32'(mon_e[7:0]));
          checkOutput("tx_eop", 32'(tx_eop), 32'(mon_e[8]));
        end
      end else if (tx_eop) begin
        checkOutput("eop_without_load", 32'd1, 32'd0);
      end
      if (pay_pop) begin
        pop_cnt++;
        pop_pend = 1'b1;
      end
      if (tx_abort || underrun) begin
        abort_cnt++;
        abort_cyc = cyc;
        checkOutput("abort_pair", 32'({tx_abort, underrun}), 32'd3);
        checkOutput("abort_no_load", 32'({tx_load, pay_pop}), 32'd0);
      end
    end
  end

  // FIFO model: pops land just after the edge on which the DUT consumed the byte.
  always begin
    @(posedge clk);
    #1;
    if (pop_pend) begin
      pop_pend = 1'b0;
      if (fifo.size() > 0) fifo.delete(0);
      refreshFifo();
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int raise_cyc;
    int g1;
    int base_pop;
    int base_abort;
    int n;

    rst = 1'b1; hs_req = 1'b0; dat_req = 1'b0;
    hs_pid = 4'd0; dat_pid = 4'd0; dat_len = 7'd0;
    crc_in = 16'h0000; tx_ready = 1'b1;
    refreshFifo();
    repeat (3) tick();
    checkOutput("reset_outputs", 32'({tx_load, tx_eop, tx_abort, pay_pop, hs_grant, dat_grant, busy, underrun}), 32'd0);
    checkOutput("reset_byte", 32'(tx_byte), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_after_reset", 32'(busy), 32'd0);

    $display("[TB] handshake ACK, back-to-back spacing");
    pushPacket(CLS_HS, PID_ACK, 7'd0);
    pushPacket(CLS_HS, PID_ACK, 7'd0);
    hs_pid = PID_ACK;
    hs_req = 1'b1;
    raise_cyc = cyc;
    waitGrants(grant_cnt + 1, 50);
    g1 = last_grant_cyc;
    checkOutput("grant_latency", 32'(g1 - raise_cyc), 32'd1);
    checkOutput("busy_in_packet", 32'(busy), 32'd1);
    waitGrants(grant_cnt + 1, 100);
    checkOutput("grant_spacing", 32'(last_grant_cyc - g1), 32'(GAP_CYCLES + 3));
    hs_req = 1'b0;
    waitIdle(200);

    $display("[TB] DATA0 len=3 with stalling serializer");
    crc_in = 16'h1234;
    fifo = '{8'hA1, 8'hB2, 8'hC3};
    refreshFifo();
    base_pop = pop_cnt;
    rand_ready = 1'b1;
    applyStimulus(CLS_DAT, PID_DATA0, 7'd3);
    waitIdle(400);
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    checkOutput("pops_len3", 32'(pop_cnt - base_pop), 32'd3);

    $display("[TB] DATA1 len=0");
    crc_in = 16'h0000;
    base_pop = pop_cnt;
    applyStimulus(CLS_DAT, PID_DATA1, 7'd0);
    waitIdle(200);
    checkOutput("pops_len0", 32'(pop_cnt - base_pop), 32'd0);

    $display("[TB] fairness with both requests held");
    crc_in = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      pushPacket(CLS_HS, PID_NAK, 7'd0);
      pushPacket(CLS_HS, PID_NAK, 7'd0);
      pushPacket(CLS_DAT, PID_DATA0, 7'd0);
    end
    hs_pid = PID_NAK;
    dat_pid = PID_DATA0;
    dat_len = 7'd0;
    hs_req = 1'b1;
    dat_req = 1'b1;
    waitGrants(grant_cnt + 6, 600);
    hs_req = 1'b0;
    dat_req = 1'b0;
    waitIdle(200);

    $display("[TB] oversize length clamped");
    crc_in = 16'hC0DE;
    fifo.delete();
    for (int i = 0; i < MAX_LEN; i++) fifo.push_back(8'(i) ^ 8'h5A);
    refreshFifo();
    base_pop = pop_cnt;
    applyStimulus(CLS_DAT, PID_DATA1, 7'd100);
    waitIdle(400);
    checkOutput("pops_clamped", 32'(pop_cnt - base_pop), 32'(MAX_LEN));
    checkOutput("fifo_drained", 32'(fifo.size()), 32'd0);

    $display("[TB] payload underrun");
    crc_in = 16'h7777;
    fifo = '{8'h11, 8'h22};
    refreshFifo();
    base_pop = pop_cnt;
    base_abort = abort_cnt;
    applyStimulus(CLS_DAT, PID_DATA0, 7'd4);
    waitIdle(200);
    checkOutput("underrun_pulses", 32'(abort_cnt - base_abort), 32'd1);
    checkOutput("pops_underrun", 32'(pop_cnt - base_pop), 32'd2);
    checkOutput("gap_after_abort", 32'(last_busy_cyc - abort_cyc), 32'(GAP_CYCLES));

    $display("[TB] reset mid-payload");
    crc_in = 16'h5555;
    fifo = '{8'h01, 8'h02, 8'h03, 8'h04};
    refreshFifo();
    base_pop = pop_cnt;
    rand_ready = 1'b1;
    applyStimulus(CLS_DAT, PID_DATA0, 7'd4);
    hs_pid = PID_STALL;
    hs_req = 1'b1;
    n = 0;
    while ((pop_cnt == base_pop) && (n < 200)) begin
      tick();
      n++;
    end
    checkOutput("reached_payload", 32'(pop_cnt > base_pop), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs", 32'({tx_load, tx_eop, tx_abort, pay_pop, hs_grant, dat_grant, busy, underrun}), 32'd0);
    checkOutput("async_reset_byte", 32'(tx_byte), 32'd0);
    exp_q.delete();
    exp_grant.delete();
    fifo.delete();
    pop_pend = 1'b0;
    refreshFifo();
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();
    checkOutput("reset_hold_outputs", 32'({tx_load, pay_pop, hs_grant, dat_grant, busy}), 32'd0);
    pushPacket(CLS_HS, PID_STALL, 7'd0);
    rst = 1'b0;
    raise_cyc = cyc;
    waitGrants(grant_cnt + 1, 50);
    checkOutput("grant_after_reset", 32'(last_grant_cyc - raise_cyc), 32'd1);
    hs_req = 1'b0;
    waitIdle(200);

    checkOutput("grants_left", 32'(exp_grant.size()), 32'd0);
    checkOutput("abort_total", 32'(abort_cnt), 32'(exp_aborts));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_packet_arbiter.md
# tx_packet_arbiter

Arbitrates the single USB transmit byte path between two packet sources, the handshake responder (ACK/NAK/STALL, PID-only) and the encrypted-data path (DATAx with payload from the data FIFO plus CRC16), and sequences each granted packet into the byte serializer. It sits between the packet-source FIFOs/CRC generator and the transmit serializer. It frames every packet as SYNC, PID, optional payload and CRC, marks end-of-packet, and enforces a minimum inter-packet idle gap.

## Interface
- GAP_CYCLES, 16: idle clock cycles enforced after each packet's last byte load (or abort) before the next grant.
- MAX_LEN, 64: maximum data payload bytes; dat_len above this is clamped to MAX_LEN.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hs_req  in  1  handshake source requests a packet; level, held until granted.
- hs_pid  in  4  handshake PID nibble.
- hs_grant  out  1  one-cycle grant pulse to the handshake source.
- dat_req  in  1  data source requests a packet; level, held until granted.
- dat_pid  in  4  DATA0/DATA1 PID nibble.
- dat_len  in  7  payload byte count, 0..MAX_LEN.
- dat_grant  out  1  one-cycle grant pulse to the data source.
- pay_empty  in  1  payload FIFO empty.
- pay_data  in  8  payload FIFO head byte (show-ahead).
- pay_pop  out  1  payload FIFO pop.
- crc_in  in  16  payload CRC16, valid from the end of payload until the packet ends.
- tx_ready  in  1  serializer can accept a byte this cycle.
- tx_load  out  1  byte transfer strobe.
- tx_byte  out  8  byte being transferred.
- tx_eop  out  1  asserted with tx_load on the last byte of a packet.
- tx_abort  out  1  one-cycle pulse on payload underrun; the serializer emits an abort sequence.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  one-cycle error pulse, coincident with tx_abort.

## Operation
- States: IDLE, SYNC, PID, PAYLOAD, CRC_LO, CRC_HI, GAP.
- IDLE selects a winner. Handshake has priority over data.
  - Fairness: hs_streak (2-bit) increments on each hs grant made while dat_req is high, and clears on any dat grant.
  - When both requests are high and hs_streak==2, data wins.
- On a decision the controller latches the class, the PID and the clamped length, then goes to SYNC.
- Byte transfer rule: in SYNC, PID, PAYLOAD, CRC_LO and CRC_HI, tx_load = tx_ready. The state and counters advance only on load.
- Byte values per state:
  - SYNC: 8'h80.
  - PID: {~pid, pid}.
  - PAYLOAD: pay_data, with pay_pop = tx_load.
  - CRC_LO: crc_in[7:0].
  - CRC_HI: crc_in[15:8].
- Sequence after PID:
  - Handshake: the PID load carries tx_eop, then GAP.
  - Data with len=0: CRC_LO next.
  - Data with len>0: PAYLOAD next. A 7-bit down-counter is loaded with len and decrements per load. At 1→0 the next state is CRC_LO. The CRC_HI load carries tx_eop, then GAP.
- Underrun: in PAYLOAD with pay_empty=1, tx_load stays 0 (even if tx_ready=1), pay_pop stays 0, tx_abort and underrun pulse, and the next state is GAP.
- GAP counts GAP_CYCLES cycles, then IDLE. Requests arriving in any non-IDLE state are held off; they are not lost because the sources hold req.
- hs_pid/dat_pid are passed through unchecked.
- Reset (asynchronous, any state, including mid-packet): state IDLE, hs_streak 0, counters 0.
  - All outputs 0: tx_byte=8'h00, tx_load, tx_eop, tx_abort, pay_pop, grants, busy, underrun.
  - A packet cut by reset is not resumed.

## Timing
- IDLE decision cycle N: the grant pulse is registered and appears in cycle N+1, the first SYNC cycle. The source may drop req from N+1.
- Earliest SYNC load is cycle N+1 when tx_ready=1.
- Load counts per packet: handshake 2; data 4+len.
- Back-to-back minimum: last load at cycle M, GAP occupies M+1..M+GAP_CYCLES, IDLE at M+GAP_CYCLES+1, next grant at M+GAP_CYCLES+2.
- tx_byte, tx_load, tx_eop and pay_pop are combinational from registered state and counters plus tx_ready/pay_empty. No input-to-output path touches the request ports.
- Simultaneous hs_req and dat_req in IDLE are resolved by the priority/fairness rule within one cycle.

## Structure
- Shared package tx_arb_pkg holds:
  - the state enum;
  - SYNC_BYTE=8'h80;
  - PID constants: ACK 4'b0010, NAK 4'b1010, STALL 4'b1110, DATA0 4'b0011, DATA1 4'b1011;
  - the packet-class enum (HS, DAT).
- One sub-module: tx_gap_timer, a loadable down-counter with a done flag, parameterised by GAP_CYCLES.

## Test plan
- hs_req=1, hs_pid=ACK, tx_ready=1 → hs_grant in the next cycle; loads 8'h80 then 8'hD2 with tx_eop; GAP for 16 cycles; busy high throughout.
- dat_req=1, DATA0, len=3, FIFO 8'hA1,8'hB2,8'hC3, crc_in=16'h1234 → loads 80,C3,A1,B2,C3,34,12; tx_eop on 8'h12; exactly 3 pay_pop.
- dat_req with len=0, DATA1, crc_in=16'h0000 → loads 80,4B,00,00; tx_eop on the last load; no pay_pop.
- hs_req and dat_req held continuously → grant order hs,hs,dat,hs,hs,dat.
- len=4 with the FIFO emptying after 2 bytes → 2 payload loads, one-cycle tx_abort and underrun pulse, no further loads, IDLE after 16 GAP cycles.
- rst asserted during PAYLOAD with tx_ready toggling → all outputs 0 immediately; after release, a pending hs_req is granted and the packet is sent from SYNC.
